neuron_seq: RTL and testbench
=============================

NEURON_SEQ -- requirements
Module: neuron_seq

Interface
REQ-001 Parameter N_IN, default 4, number of input/weight pairs per neuron evaluation (2..16).
REQ-002 Parameter THRESH, default 8'd16, step-activation threshold.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 w_we  input  1  weight write strobe; w_addr  input  4  weight index; w_data  input  4  weight value.
REQ-006 in_valid  input  1 / in_ready  output  1 / in_x  input  4  activation stream, one element per handshake.
REQ-007 mac_x  output  4 / mac_w  output  4 / mac_prev  output  8  operands to downstream MAC stage.
REQ-008 mac_out  input  8  MAC result; valid two rising edges after mac_x/mac_w sampled, using mac_prev sampled on the second edge.
REQ-009 res_valid  output  1 / res_ready  input  1 / res_sum  output  8 / res_fire  output  1  result handshake.

Function
REQ-010 The block SHALL implement an FSM: IDLE, LOAD, ISSUE, SUM, CAPT, DONE.
REQ-011 IDLE: in_ready=1; accepted element (in_valid&in_ready) stored as x[0], go LOAD, index=1.
REQ-012 LOAD: in_ready=1; each handshake stores x[idx], idx++; after element N_IN-1 go ISSUE, idx=0, acc=0.
REQ-013 ISSUE: mac_x=x[idx], mac_w=w[idx] for exactly one cycle; next SUM.
REQ-014 SUM: mac_prev=acc; mac_x/mac_w held; next CAPT.
REQ-015 CAPT: acc<=mac_out; if idx==N_IN-1 go DONE else idx++, go ISSUE; three cycles per term.
REQ-016 mac_prev SHALL equal acc in every state; mac_x/mac_w SHALL be 0 outside ISSUE/SUM/CAPT.
REQ-017 in_ready SHALL be 0 in ISSUE, SUM, CAPT, DONE.
REQ-018 DONE: res_valid=1, res_sum=acc, res_fire=(acc>=THRESH); outputs held stable until res_ready; on res_valid&res_ready go IDLE same edge.
REQ-019 Accumulation SHALL be 8-bit modulo (wrap) unless REQ-026 enabled.
REQ-020 Weight writes (w_we) SHALL take effect on the next edge in any state; a write to the index being issued in ISSUE SHALL not alter mac_w until the following term; w_addr>=N_IN ignored.
REQ-021 Evaluation latency from last input handshake to res_valid SHALL be 3*N_IN+1 cycles.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, idx=0, acc=0, x[]=0, w[]=0.
REQ-023 During reset: in_ready=0, res_valid=0, res_sum=0, res_fire=0, mac_x=mac_w=mac_prev=0; in_ready=1 from the first edge after release.
REQ-024 Reset mid-evaluation SHALL discard the partial sum; no res_valid produced for it.

Configuration
REQ-025 Macro NEURON_SEQ_SAT_EN selects saturating accumulation.
REQ-026 With it: in CAPT, if mac_out<acc (wrap) acc SHALL become 8'hFF and stay 8'hFF for the rest of the evaluation; without it, acc takes mac_out unconditionally.

Structure
REQ-027 Package neuron_pkg SHALL hold the FSM state enum, X_W=4, W_W=4, ACC_W=8.
REQ-028 Weight storage SHALL be sub-module neuron_wrf (N_IN x 4-bit, one write port, one async read port).

Verification
REQ-029 Weights {1,2,3,4}, inputs {1,1,1,1}, THRESH 16 -> res_sum=10, res_fire=0 after 13 cycles.
REQ-030 Weights all 15, inputs all 15 -> res_sum=900 mod 256=132; with NEURON_SEQ_SAT_EN res_sum=255, res_fire=1.
REQ-031 Inputs {4,4,0,0}, weights {2,2,0,0} -> res_sum=16, res_fire=1 (boundary equality).
REQ-032 res_ready held low 10 cycles -> res_valid/res_sum stable, in_ready=0; assert res_ready -> IDLE next cycle.
REQ-033 rst_n pulsed low during CAPT of term 2 -> all outputs 0 immediately; next full evaluation correct.
REQ-034 in_valid gaps between elements -> same res_sum as gap-free run; w_we during SUM of term 0 to index 0 -> affects next evaluation only.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and widths for the sequential neuron.
// FSM state encoding, operand widths, saturation value, index sizing.
package neuron_pkg;

  localparam int X_W   = 4;
  localparam int W_W   = 4;
  localparam int ACC_W = 8;

  localparam logic [ACC_W-1:0] ACC_SAT = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_SUM,
    S_CAPT,
    S_DONE
  } state_t;

  function automatic int idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/neuron_wrf.sv
// neuron_wrf: N_IN x 4-bit weight register file.
// One synchronous write port, one asynchronous read port.
module neuron_wrf
  import neuron_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int IW   = idx_bits(N_IN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [3:0]     waddr,
  input  logic [W_W-1:0] wdata,
  input  logic [IW-1:0]  raddr,
  output logic [W_W-1:0] rdata
);

  logic [W_W-1:0] mem [N_IN];
  logic           in_range;

  assign in_range = ({1'b0, waddr} < 5'(N_IN));
  assign rdata    = mem[raddr];

  // Weight storage; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) mem[i] <= '0;
    end else if (we && in_range) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/neuron_seq.sv
// neuron_seq: sequential dot-product neuron with step activation.
// Define NEURON_SEQ_SAT_EN for saturating accumulation.
module neuron_seq
  import neuron_pkg::*;
#(
  parameter int               N_IN   = 4,
  parameter logic [ACC_W-1:0] THRESH = 8'd16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_we,
  input  logic [3:0]       w_addr,
  input  logic [W_W-1:0]   w_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  output logic [X_W-1:0]   mac_x,
  output logic [W_W-1:0]   mac_w,
  output logic [ACC_W-1:0] mac_prev,
  input  logic [ACC_W-1:0] mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_sum,
  output logic             res_fire
);

  localparam int            IW   = idx_bits(N_IN);
  localparam logic [IW-1:0] LAST = IW'(N_IN - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    rd_idx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [X_W-1:0]   x_q [N_IN];
  logic [X_W-1:0]   mx_q;
  logic [W_W-1:0]   mw_q;
  logic [W_W-1:0]   rd_w;
  logic             in_rdy_q;
  logic             res_vld_q;
  logic             in_hs;

  // Index of the term about to be issued.
  assign rd_idx = (state == S_CAPT) ? idx + 1'b1 : '0;

  neuron_wrf #(
    .N_IN (N_IN),
    .IW   (IW)
  ) u_wrf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr (w_addr),
    .wdata (w_data),
    .raddr (rd_idx),
    .rdata (rd_w)
  );

`ifdef NEURON_SEQ_SAT_EN
  // Pin at full scale once the MAC wraps.
  assign acc_nxt = (acc == ACC_SAT || mac_out < acc) ? ACC_SAT : mac_out;
`else
  assign acc_nxt = mac_out;
`endif

  assign in_hs     = in_valid && in_rdy_q;
  assign in_ready  = in_rdy_q;
  assign res_valid = res_vld_q;
  assign res_sum   = res_vld_q ? acc : '0;
  assign res_fire  = res_vld_q && (acc >= THRESH);
  assign mac_x     = mx_q;
  assign mac_w     = mw_q;
  assign mac_prev  = acc;

  // Control FSM with registered handshake and MAC operand outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      acc       <= '0;
      mx_q      <= '0;
      mw_q      <= '0;
      in_rdy_q  <= 1'b0;
      res_vld_q <= 1'b0;
      for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          in_rdy_q <= 1'b1;
          if (in_hs) begin
            x_q[idx] <= in_x;
            idx      <= idx + 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_hs) begin
            x_q[idx] <= in_x;
            if (idx == LAST) begin
              idx      <= '0;
              acc      <= '0;
              in_rdy_q <= 1'b0;
              mx_q     <= x_q[0];
              mw_q     <= rd_w;
              state    <= S_ISSUE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_ISSUE: state <= S_SUM;
        S_SUM:   state <= S_CAPT;
        S_CAPT: begin
          acc <= acc_nxt;
          if (idx == LAST) begin
            mx_q      <= '0;
            mw_q      <= '0;
            res_vld_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            mx_q  <= x_q[rd_idx];
            mw_q  <= rd_w;
            state <= S_ISSUE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            idx       <= '0;
            res_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq.sv
// tb_neuron_seq: scoreboard bench for neuron_seq.
// Directed vectors; a MAC model supplies mac_out.
module tb_neuron_seq;

  localparam int N = 4;

  typedef struct {
    logic [7:0] sum;
    logic       fire;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       w_we;
  logic [3:0] w_addr;
  logic [3:0] w_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [3:0] mac_x;
  logic [3:0] mac_w;
  logic [7:0] mac_prev;
  logic [7:0] mac_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_sum;
  logic       res_fire;

  logic [7:0] prod_q;
  exp_t       sb [$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;
  int         hs_cyc = 0;
  logic       rv_d   = 1'b0;

  neuron_seq #(
    .N_IN   (N),
    .THRESH (8'd16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .mac_x     (mac_x),
    .mac_w     (mac_w),
    .mac_prev  (mac_prev),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_fire  (res_fire)
  );

  always #5 clk = ~clk;

  // Downstream MAC: product on edge 1, add mac_prev on edge 2.
  always @(posedge clk) begin
    prod_q  <= 8'(mac_x) * 8'(mac_w);
    mac_out <= prod_q + mac_prev;
    cyc     <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: latency, backpressure and scoreboard comparison.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && !rv_d)
        chk("latency", cyc - hs_cyc, 3 * N + 1);
      if (res_valid)
        chk("in_ready_in_done", int'(in_ready), 0);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_sum", int'(res_sum), int'(e.sum));
          chk("res_fire", int'(res_fire), int'(e.fire));
        end
      end
    end
    rv_d = res_valid;
  end

  task automatic set_w(input logic [15:0] wv);
    for (int i = 0; i < N; i++) begin
      w_we   = 1'b1;
      w_addr = 4'(i);
      w_data = wv[4*i +: 4];
      @(negedge clk);
    end
    w_we = 1'b0;
  endtask

  task automatic send_x(input logic [3:0] v, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_x     = v;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", n, 0);
    hs_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_all(input logic [15:0] xv,
                          input logic [15:0] gv);
    for (int i = 0; i < N; i++)
      send_x(xv[4*i +: 4], int'(gv[4*i +: 4]));
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", n, (n < 300) ? n : -1);
    @(negedge clk);
  endtask

  task automatic run_eval(input logic [15:0] xv,
                          input logic [15:0] gv,
                          input logic [7:0]  es,
                          input logic        ef);
    exp_t e;
    e.sum  = es;
    e.fire = ef;
    sb.push_back(e);
    send_all(xv, gv);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    in_valid  = 1'b0;
    in_x      = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_sum", int'(res_sum), 0);
    chk("rst_res_fire", int'(res_fire), 0);
    chk("rst_mac_x", int'(mac_x), 0);
    chk("rst_mac_w", int'(mac_w), 0);
    chk("rst_mac_prev", int'(mac_prev), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", int'(in_ready), 1);

    set_w(16'h4321);
    run_eval(16'h1111, 16'h0000, 8'd10, 1'b0);

    set_w(16'hFFFF);
`ifdef NEURON_SEQ_SAT_EN
    run_eval(16'hFFFF, 16'h0000, 8'd255, 1'b1);
`else
    run_eval(16'hFFFF, 16'h0000, 8'd132, 1'b1);
`endif

    set_w(16'h0022);
    run_eval(16'h0044, 16'h0000, 8'd16, 1'b1);
    chk("idle_mac_x", int'(mac_x), 0);
    chk("idle_mac_w", int'(mac_w), 0);

    set_w(16'h4321);
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    begin
      exp_t e;
      e.sum  = 8'd20;
      e.fire = 1'b1;
      sb.push_back(e);
    end
    send_all(16'h2222, 16'h0000);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_timeout", n, (n < 100) ? n : -1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_res_valid", int'(res_valid), 1);
      chk("bp_res_sum", int'(res_sum), 20);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", int'(res_valid), 0);
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_sb_empty", sb.size(), 0);

    send_all(16'h3333, 16'h0000);
    while (cyc < hs_cyc + 9) @(negedge clk);
    chk("capt2_mac_prev", int'(mac_prev), 9);
    chk("capt2_mac_x", int'(mac_x), 3);
    chk("capt2_mac_w", int'(mac_w), 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_mac_prev", int'(mac_prev), 0);
    chk("midrst_mac_x", int'(mac_x), 0);
    chk("midrst_mac_w", int'(mac_w), 0);
    chk("midrst_res_valid", int'(res_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_back", int'(in_ready), 1);

    run_eval(16'h5555, 16'h0000, 8'd0, 1'b0);

    set_w(16'h4321);
    begin
      exp_t e;
      e.sum  = 8'd10;
      e.fire = 1'b0;
      sb.push_back(e);
    end
    send_all(16'h1111, 16'h1302);
    while (cyc < hs_cyc + 2) @(negedge clk);
    w_we   = 1'b1;
    w_addr = 4'd0;
    w_data = 4'd5;
    @(negedge clk);
    w_we = 1'b0;
    wait_done();

    w_we   = 1'b1;
    w_addr = 4'd4;
    w_data = 4'd15;
    @(negedge clk);
    w_we = 1'b0;
    run_eval(16'h1111, 16'h0000, 8'd14, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
